alu_seq: RTL

Parametrised, handshaked ALU that generalises the team's 4-bit inverter and adder components to WIDTH-bit operands. It adds subtract, logic ops, increment and a multi-cycle shift-and-add multiply, and produces registered carry/zero/overflow flags. It sits between the operand/decode stage and the register write-back stage. Valid/ready handshakes on both sides let upstream and downstream stall independently.

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic ops, shift-and-add multiply,
// registered result with carry/zero/overflow flags.
module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic [SW-1:0]     sum;
    logic [WIDTH-1:0]  alu_r;
    logic              alu_c;
    logic              alu_v;

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Single-cycle datapath for every op except MUL
    always_comb begin
        sum   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + SW'(1);
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            OP_INC: begin
                sum   = {1'b0, a} + SW'(1);
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = !a[MSB] && alu_r[MSB];
            end
            OP_NOT:  alu_r = ~a;
            OP_AND:  alu_r = a & b;
            OP_OR:   alu_r = a | b;
            OP_XOR:  alu_r = a ^ b;
            default: alu_r = '0;
        endcase
    end

    // Control FSM; MUL runs WIDTH add steps then one cycle to commit the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand     <= {{WIDTH{1'b0}}, a};
                            mplier    <= b;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= S_MUL;
                        end else begin
                            result    <= alu_r;
                            carry     <= alu_c;
                            zero      <= (alu_r == '0);
                            ovf       <= alu_v;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt == CW'(WIDTH)) begin
                        result    <= acc[WIDTH-1:0];
                        carry     <= |acc[PW-1:WIDTH];
                        zero      <= (acc[WIDTH-1:0] == '0);
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
